mfp_ahb_lite_master: RTL and testbench

Command-driven AHB-Lite initiator that converts single read/write requests into AHB-Lite SINGLE transfers, with address/data phase pipelining. It lets on-chip agents (debug bridge, DMA-lite, test sequencer) drive MIPSfpga+ slaves such as the EIC without a CPU. Responses come back in order, one per accepted command, with read data and an error flag. Misaligned or illegal-size commands are rejected in order without a bus transfer.

---
 rtl/mfp_ahb_lite_master.sv | 101 ++++++++++
 tb/tb_mfp_ahb_lite_master.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfp_ahb_lite_master.sv
// mfp_ahb_lite_master: command-driven AHB-Lite initiator issuing pipelined SINGLE transfers
// with in-order responses and local rejection of misaligned commands.
module mfp_ahb_lite_master #(
  parameter logic [3:0] HPROT_VALUE = 4'b0011,
  parameter bit         ALIGN_CHECK = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic        rsp_write,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        busy,
  output logic [31:0] HADDR,
  output logic [2:0]  HBURST,
  output logic        HMASTLOCK,
  output logic [3:0]  HPROT,
  output logic [2:0]  HSIZE,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);
  typedef struct packed {
    logic        valid;
    logic        write;
    logic        phantom;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } a_slot_t;
  localparam a_slot_t A_RESET = '{valid: 1'b0, write: 1'b0, phantom: 1'b0, size: 3'b010, addr: '0, wdata: '0};
  a_slot_t     a_q, a_d;
  logic        d_valid_q, d_valid_d, d_write_q, d_write_d, d_phantom_q, d_phantom_d;
  logic [31:0] d_wdata_q, d_wdata_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d, rsp_error_q, rsp_error_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        accept, misaligned;
  assign cmd_ready  = ~a_q.valid | HREADY;
  assign accept     = cmd_valid & cmd_ready;
  assign misaligned = (cmd_size == 3'd1 & cmd_addr[0]) | (cmd_size == 3'd2 & |cmd_addr[1:0]) | (cmd_size > 3'd2);
  always_comb begin
    a_d         = a_q;
    a_d.valid   = a_q.valid & ~HREADY;
    if (accept)
      a_d = '{valid: 1'b1, write: cmd_write, phantom: ALIGN_CHECK & misaligned, size: cmd_size, addr: cmd_addr, wdata: cmd_wdata};
    d_valid_d   = HREADY ? a_q.valid   : d_valid_q;
    d_write_d   = HREADY ? a_q.write   : d_write_q;
    d_phantom_d = HREADY ? a_q.phantom : d_phantom_q;
    d_wdata_d   = HREADY ? a_q.wdata   : d_wdata_q;
    // the data phase retires only on a ready edge; the first ERROR cycle is just a wait
    rsp_valid_d = HREADY & d_valid_q;
    rsp_write_d = rsp_valid_d & d_write_q;
    rsp_error_d = rsp_valid_d & (d_phantom_q | HRESP);
    rsp_rdata_d = (rsp_valid_d & ~d_write_q & ~d_phantom_q & ~HRESP) ? HRDATA : '0;
  end
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      a_q         <= A_RESET;
      d_valid_q   <= 1'b0;
      d_write_q   <= 1'b0;
      d_phantom_q <= 1'b0;
      d_wdata_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      a_q         <= a_d;
      d_valid_q   <= d_valid_d;
      d_write_q   <= d_write_d;
      d_phantom_q <= d_phantom_d;
      d_wdata_q   <= d_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end
  assign HTRANS    = (a_q.valid & ~a_q.phantom) ? 2'b10 : 2'b00;
  assign HADDR     = a_q.addr;
  assign HWRITE    = a_q.write;
  assign HSIZE     = a_q.size;
  assign HWDATA    = d_wdata_q;
  assign HBURST    = 3'b000;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = HPROT_VALUE;
  assign busy      = a_q.valid | d_valid_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_error = rsp_error_q;
  assign rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_mfp_ahb_lite_master.sv
// tb_mfp_ahb_lite_master: vector table of single commands, directed pipeline corner cases,
// and a randomized run against a memory-backed slave and an in-order response model.
module tb_mfp_ahb_lite_master;
  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [2:0]  cmd_size = 3'd2;
  logic        cmd_ready, rsp_valid, rsp_write, rsp_error, busy, HMASTLOCK, HWRITE;
  logic [31:0] rsp_rdata, HADDR, HWDATA;
  logic [2:0]  HBURST, HSIZE;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic [31:0] HRDATA = '0;
  logic        HREADY = 1'b1, HRESP = 1'b0;
  int          checks = 0, errors = 0;
  localparam int NRAND = 400;

  typedef struct {
    logic w; logic [31:0] a; logic [2:0] s; logic [31:0] d; logic [31:0] hr;
    logic ns; logic e; logic [31:0] rd;
  } vec_t;
  typedef struct { logic w; logic e; logic [31:0] d; } rsp_t;

  vec_t        vt[11];
  rsp_t        exp_q[$];
  rsp_t        er;
  logic [31:0] m_mem[64], s_mem[64];
  int          gen, nrsp, dp_wait;
  logic        p_acc, p_ns, p_rdy, p_w, p_hw, dp_v, dp_w, dp_e, dp_st, m_err;
  logic [31:0] p_a, p_d, p_ha, p_hwd, dp_a;
  logic [2:0]  p_s, p_hs, dp_s;

  mfp_ahb_lite_master dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .busy(busy), .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
    .HSIZE(HSIZE), .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_rsp(input string nm, input logic w, input logic e, input logic [31:0] d);
    chk($sformatf("%s_valid", nm), 32'(rsp_valid), 1);
    chk($sformatf("%s_write", nm), 32'(rsp_write), 32'(w));
    chk($sformatf("%s_error", nm), 32'(rsp_error), 32'(e));
    chk($sformatf("%s_rdata", nm), rsp_rdata, d);
  endtask

  task automatic put(input logic w, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_size = s; cmd_wdata = d;
  endtask

  function automatic logic misal(input logic [2:0] s, input logic [31:0] a);
    return (s == 3'd1 && a[0]) || (s == 3'd2 && a[1:0] != 2'b00) || s > 3'd2;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] s, input logic [31:0] a);
    if (s == 3'd0) return 4'b0001 << a[1:0];
    if (s == 3'd1) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] mrg(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] m);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = m[b] ? nw[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

  initial begin
    // {write, addr, size, wdata, hrdata, expect NONSEQ, expect error, expect rdata}
    vt[0]  = '{1'b1, 32'h04, 3'd2, 32'h12345678, 32'h0,        1'b1, 1'b0, 32'h0};
    vt[1]  = '{1'b0, 32'h08, 3'd2, 32'h0,        32'hCAFE0001, 1'b1, 1'b0, 32'hCAFE0001};
    vt[2]  = '{1'b1, 32'h02, 3'd2, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b1, 32'h0};
    vt[3]  = '{1'b0, 32'h11, 3'd1, 32'h0,        32'h13572468, 1'b0, 1'b1, 32'h0};
    vt[4]  = '{1'b0, 32'h12, 3'd1, 32'h0,        32'hAAAA5555, 1'b1, 1'b0, 32'hAAAA5555};
    vt[5]  = '{1'b0, 32'h13, 3'd0, 32'h0,        32'h01020304, 1'b1, 1'b0, 32'h01020304};
    vt[6]  = '{1'b1, 32'h20, 3'd3, 32'h00000001, 32'h0,        1'b0, 1'b1, 32'h0};
    vt[7]  = '{1'b0, 32'h40, 3'd4, 32'h0,        32'h00009999, 1'b0, 1'b1, 32'h0};
    vt[8]  = '{1'b1, 32'h03, 3'd0, 32'hAB000000, 32'h0,        1'b1, 1'b0, 32'h0};
    vt[9]  = '{1'b0, 32'h1E, 3'd2, 32'h0,        32'h00000077, 1'b0, 1'b1, 32'h0};
    vt[10] = '{1'b1, 32'h1A, 3'd1, 32'h5A5A0000, 32'h0,        1'b1, 1'b0, 32'h0};

    @(negedge HCLK);
    chk("rst_htrans", 32'(HTRANS), 0);
    chk("rst_haddr", HADDR, 0);
    chk("rst_hwrite", 32'(HWRITE), 0);
    chk("rst_hsize", 32'(HSIZE), 2);
    chk("rst_hwdata", HWDATA, 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_write", 32'(rsp_write), 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_error", 32'(rsp_error), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_hburst", 32'(HBURST), 0);
    chk("rst_hmastlock", 32'(HMASTLOCK), 0);
    chk("rst_hprot", 32'(HPROT), 3);
    HRESET = 1'b0;

    for (int i = 0; i < 11; i++) begin
      @(negedge HCLK);
      put(vt[i].w, vt[i].a, vt[i].s, vt[i].d);
      #1 chk($sformatf("vec%0d_ready", i), 32'(cmd_ready), 1);
      @(negedge HCLK);
      cmd_valid = 1'b0;
      HRDATA = vt[i].hr;
      chk($sformatf("vec%0d_htrans", i), 32'(HTRANS), vt[i].ns ? 2 : 0);
      if (vt[i].ns) begin
        chk($sformatf("vec%0d_haddr", i), HADDR, vt[i].a);
        chk($sformatf("vec%0d_hwrite", i), 32'(HWRITE), 32'(vt[i].w));
        chk($sformatf("vec%0d_hsize", i), 32'(HSIZE), 32'(vt[i].s));
      end
      chk($sformatf("vec%0d_busy", i), 32'(busy), 1);
      @(negedge HCLK);
      chk($sformatf("vec%0d_idle", i), 32'(HTRANS), 0);
      if (vt[i].w && vt[i].ns) chk($sformatf("vec%0d_hwdata", i), HWDATA, vt[i].d);
      chk($sformatf("vec%0d_early", i), 32'(rsp_valid), 0);
      @(negedge HCLK);
      chk_rsp($sformatf("vec%0d", i), vt[i].w, vt[i].e, vt[i].rd);
      chk($sformatf("vec%0d_busy_end", i), 32'(busy), 0);
      @(negedge HCLK);
      chk($sformatf("vec%0d_pulse", i), 32'(rsp_valid), 0);
    end

    // read with two wait states while a write sits in A and a third command waits
    @(negedge HCLK); put(1'b0, 32'h08, 3'd2, 32'h0);
    @(negedge HCLK); chk("ws_ns", 32'(HTRANS), 2); put(1'b1, 32'h30, 3'd2, 32'h55AA55AA);
    @(negedge HCLK); put(1'b0, 32'h34, 3'd2, 32'h0); HREADY = 1'b0; HRDATA = 32'hFFFF0000;
    #1 chk("ws_ready0", 32'(cmd_ready), 0); chk("ws_haddr0", HADDR, 32'h30);
    @(negedge HCLK); chk("ws_rsp0", 32'(rsp_valid), 0);
    #1 chk("ws_ready1", 32'(cmd_ready), 0); chk("ws_ns_hold", 32'(HTRANS), 2);
    @(negedge HCLK); chk("ws_rsp1", 32'(rsp_valid), 0); HREADY = 1'b1; HRDATA = 32'hCAFE0001;
    #1 chk("ws_ready2", 32'(cmd_ready), 1);
    @(negedge HCLK); chk_rsp("ws_read", 1'b0, 1'b0, 32'hCAFE0001);
    chk("ws_hwdata", HWDATA, 32'h55AA55AA); chk("ws_haddr2", HADDR, 32'h34);
    cmd_valid = 1'b0; HRDATA = 32'h0BADF00D;
    @(negedge HCLK); chk_rsp("ws_write", 1'b1, 1'b0, 32'h0);
    @(negedge HCLK); chk_rsp("ws_read2", 1'b0, 1'b0, 32'h0BADF00D);
    @(negedge HCLK); chk("ws_end_rsp", 32'(rsp_valid), 0); chk("ws_end_busy", 32'(busy), 0);

    // back-to-back write, read, write
    @(negedge HCLK); put(1'b1, 32'h40, 3'd2, 32'h11112222);
    @(negedge HCLK); chk("b2b_ns0", 32'(HTRANS), 2); chk("b2b_a0", HADDR, 32'h40); chk("b2b_w0", 32'(HWRITE), 1);
    put(1'b0, 32'h44, 3'd2, 32'h0);
    @(negedge HCLK); chk("b2b_ns1", 32'(HTRANS), 2); chk("b2b_a1", HADDR, 32'h44); chk("b2b_w1", 32'(HWRITE), 0);
    chk("b2b_wd0", HWDATA, 32'h11112222); put(1'b1, 32'h48, 3'd2, 32'h33334444);
    @(negedge HCLK); chk_rsp("b2b_r0", 1'b1, 1'b0, 32'h0); chk("b2b_ns2", 32'(HTRANS), 2); chk("b2b_a2", HADDR, 32'h48);
    cmd_valid = 1'b0; HRDATA = 32'h600DD00D;
    @(negedge HCLK); chk_rsp("b2b_r1", 1'b0, 1'b0, 32'h600DD00D); chk("b2b_idle", 32'(HTRANS), 0);
    chk("b2b_wd2", HWDATA, 32'h33334444);
    @(negedge HCLK); chk_rsp("b2b_r2", 1'b1, 1'b0, 32'h0);
    @(negedge HCLK); chk("b2b_end", 32'(rsp_valid), 0);

    // two-cycle ERROR on a read with a write queued behind it
    @(negedge HCLK); put(1'b0, 32'h50, 3'd2, 32'h0);
    @(negedge HCLK); put(1'b1, 32'h54, 3'd2, 32'h76543210);
    @(negedge HCLK); cmd_valid = 1'b0; HREADY = 1'b0; HRESP = 1'b1; HRDATA = 32'hDEADBEEF;
    @(negedge HCLK); chk("err_wait_rsp", 32'(rsp_valid), 0); chk("err_a_kept", 32'(HTRANS), 2);
    chk("err_a_addr", HADDR, 32'h54); HREADY = 1'b1;
    @(negedge HCLK); chk_rsp("err_read", 1'b0, 1'b1, 32'h0); chk("err_hwdata", HWDATA, 32'h76543210);
    HRESP = 1'b0;
    @(negedge HCLK); chk_rsp("err_next", 1'b1, 1'b0, 32'h0);
    @(negedge HCLK); chk("err_end", 32'(rsp_valid), 0);

    // misaligned write between two reads
    @(negedge HCLK); put(1'b0, 32'h60, 3'd2, 32'h0);
    @(negedge HCLK); chk("ph_ns0", 32'(HTRANS), 2); put(1'b1, 32'h02, 3'd2, 32'hAAAAAAAA);
    @(negedge HCLK); chk("ph_idle", 32'(HTRANS), 0); put(1'b0, 32'h64, 3'd2, 32'h0); HRDATA = 32'h11110000;
    @(negedge HCLK); chk_rsp("ph_r0", 1'b0, 1'b0, 32'h11110000); chk("ph_ns2", 32'(HTRANS), 2);
    chk("ph_a2", HADDR, 32'h64); cmd_valid = 1'b0;
    @(negedge HCLK); chk_rsp("ph_w", 1'b1, 1'b1, 32'h0); HRDATA = 32'h22220000;
    @(negedge HCLK); chk_rsp("ph_r1", 1'b0, 1'b0, 32'h22220000);
    @(negedge HCLK); chk("ph_end", 32'(rsp_valid), 0);

    // reset asserted in the middle of a three-cycle wait state
    @(negedge HCLK); put(1'b0, 32'h70, 3'd2, 32'h0);
    @(negedge HCLK); put(1'b1, 32'h74, 3'd2, 32'h99999999);
    @(negedge HCLK); cmd_valid = 1'b0; HREADY = 1'b0;
    @(negedge HCLK);
    @(negedge HCLK); chk("rw_ns", 32'(HTRANS), 2);
    #2 HRESET = 1'b1;
    #1 chk("rw_htrans", 32'(HTRANS), 0); chk("rw_busy", 32'(busy), 0);
    chk("rw_rsp", 32'(rsp_valid), 0); chk("rw_haddr", HADDR, 0);
    @(negedge HCLK); chk("rw_rsp1", 32'(rsp_valid), 0); HRESET = 1'b0; HREADY = 1'b1;
    @(negedge HCLK); chk("rw_rsp2", 32'(rsp_valid), 0); chk("rw_busy2", 32'(busy), 0);
    put(1'b0, 32'h78, 3'd2, 32'h0); HRDATA = 32'h5EED0078;
    @(negedge HCLK); chk("rw_ns2", 32'(HTRANS), 2); chk("rw_a2", HADDR, 32'h78); cmd_valid = 1'b0;
    @(negedge HCLK); chk("rw_rsp3", 32'(rsp_valid), 0);
    @(negedge HCLK); chk_rsp("rw_after", 1'b0, 1'b0, 32'h5EED0078);
    @(negedge HCLK); chk("rw_end", 32'(rsp_valid), 0);

    // randomized traffic: slave memory with wait states and ERROR region 0xE0-0xEF
    for (int i = 0; i < 64; i++) begin
      m_mem[i] = 32'hC0DE0000 | 32'(i);
      s_mem[i] = m_mem[i];
    end
    gen = 0; nrsp = 0; p_acc = 1'b0; p_ns = 1'b0; p_rdy = 1'b1; dp_v = 1'b0; dp_wait = 0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge HCLK);
      if (p_acc) begin
        m_err = misal(p_s, p_a) || p_a[7:4] == 4'hE;
        if (p_w && !m_err) m_mem[p_a[7:2]] = mrg(m_mem[p_a[7:2]], p_d, lane_mask(p_s, p_a));
        exp_q.push_back('{p_w, m_err, (!p_w && !m_err) ? m_mem[p_a[7:2]] : 32'h0});
      end
      if (p_rdy) begin
        if (dp_v && dp_w && !dp_e) s_mem[dp_a[7:2]] = mrg(s_mem[dp_a[7:2]], p_hwd, lane_mask(dp_s, dp_a));
        dp_v = p_ns;
        if (p_ns) begin
          dp_w = p_hw; dp_a = p_ha; dp_s = p_hs; dp_e = p_ha[7:4] == 4'hE;
          dp_wait = int'($urandom_range(0, 2)); dp_st = 1'b0;
        end
      end
      if (rsp_valid) begin
        nrsp++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rand_rsp_unexpected: got a response with none outstanding");
        end else begin
          er = exp_q.pop_front();
          chk("rand_rsp_write", 32'(rsp_write), 32'(er.w));
          chk("rand_rsp_error", 32'(rsp_error), 32'(er.e));
          chk("rand_rsp_rdata", rsp_rdata, er.d);
        end
      end
      if (gen == NRAND && !cmd_valid && exp_q.size() == 0 && !busy) break;
      HRDATA = $urandom;
      if (!dp_v) begin
        HREADY = 1'b1; HRESP = 1'b0;
      end else if (dp_wait > 0) begin
        HREADY = 1'b0; HRESP = 1'b0; dp_wait--;
      end else if (dp_e && !dp_st) begin
        HREADY = 1'b0; HRESP = 1'b1; dp_st = 1'b1;
      end else begin
        HREADY = 1'b1; HRESP = dp_e;
        if (!dp_w) HRDATA = s_mem[dp_a[7:2]];
      end
      if (!cmd_valid || p_acc) begin
        cmd_valid = 1'b0;
        if (gen < NRAND && $urandom_range(0, 3) != 0) begin
          gen++;
          cmd_valid = 1'b1;
          cmd_write = 1'($urandom_range(0, 1));
          cmd_addr  = 32'($urandom_range(0, 255));
          cmd_size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
          cmd_wdata = $urandom;
          if (cmd_size <= 3'd2 && $urandom_range(0, 1) == 1)
            cmd_addr = cmd_addr & ~((32'd1 << cmd_size) - 32'd1);
        end
      end
      #1;
      p_acc = cmd_valid & cmd_ready;
      p_ns  = HTRANS == 2'b10;
      p_rdy = HREADY;
      p_w = cmd_write; p_a = cmd_addr; p_s = cmd_size; p_d = cmd_wdata;
      p_ha = HADDR; p_hw = HWRITE; p_hs = HSIZE; p_hwd = HWDATA;
    end
    chk("rand_drain", 32'(exp_q.size()), 0);
    chk("rand_rsp_count", 32'(nrsp), NRAND);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
